// File: rtl/idft_axi4lite_slave.sv
// rtl/idft_axi4lite_slave.sv - AXI4-lite responder converting bus transactions into single-cycle register-bus accesses
//
// Purpose: slave end of the AXI4-lite bus in front of the IDFT register file.
//   Each accepted write or read becomes a single-cycle pulse on the register bus.
//   One transaction can be outstanding per direction.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   i_axi_aw*/o_axi_awready  write address channel
//   i_axi_w*/o_axi_wready    write data channel (DW data, DW/8 strobes)
//   o_axi_b*/i_axi_bready    write response channel
//   i_axi_ar*/o_axi_arready  read address channel
//   o_axi_r*/i_axi_rready    read data channel
//   o_reg_wr_*               register write pulse, word index, data, byte enables
//   o_reg_rd_*               register read pulse and word index
//   i_reg_rd_data            register read data, valid the cycle after o_reg_rd_en
module idft_axi4lite_slave #(
  parameter int          AW        = 32,
  parameter int          DW        = 64,
  parameter logic [31:0] ADDR_SPAN = 32'h0000_1000,
  parameter int          RW        = 9
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [AW-1:0]   i_axi_awaddr,
  input  logic            i_axi_awvalid,
  output logic            o_axi_awready,
  input  logic [DW-1:0]   i_axi_wdata,
  input  logic [DW/8-1:0] i_axi_wstrb,
  input  logic            i_axi_wvalid,
  output logic            o_axi_wready,
  output logic [1:0]      o_axi_bresp,
  output logic            o_axi_bvalid,
  input  logic            i_axi_bready,
  input  logic [AW-1:0]   i_axi_araddr,
  input  logic            i_axi_arvalid,
  output logic            o_axi_arready,
  output logic [DW-1:0]   o_axi_rdata,
  output logic [1:0]      o_axi_rresp,
  output logic            o_axi_rvalid,
  input  logic            i_axi_rready,
  output logic            o_reg_wr_en,
  output logic [RW-1:0]   o_reg_wr_idx,
  output logic [DW-1:0]   o_reg_wr_data,
  output logic [DW/8-1:0] o_reg_wr_strb,
  output logic            o_reg_rd_en,
  output logic [RW-1:0]   o_reg_rd_idx,
  input  logic [DW-1:0]   i_reg_rd_data
);

  localparam int          OFF    = $clog2(DW/8);
  localparam logic [AW-1:0] SPAN = AW'(ADDR_SPAN);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic            r_aw_cap, r_w_cap;
  logic [AW-1:0]   r_awaddr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic [1:0]      r_bresp;

  logic [AW-1:0]   r_araddr;
  logic [DW-1:0]   r_rdata;
  logic [1:0]      r_rresp;

  logic w_aw_hs, w_w_hs, w_ar_hs;
  logic w_wr_in_range, w_rd_in_range;
  logic w_wr_en, w_rd_en;

  assign w_wr_in_range = (r_awaddr < SPAN);
  assign w_rd_in_range = (r_araddr < SPAN);

  // ---------------- write FSM ----------------
  always_comb begin
    w_wstate_nxt  = r_wstate;
    o_axi_awready = 1'b0;
    o_axi_wready  = 1'b0;
    o_axi_bvalid  = 1'b0;
    w_wr_en       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        o_axi_awready = !r_aw_cap;
        o_axi_wready  = !r_w_cap;
        // Count a handshake happening this cycle so the issue follows immediately.
        if ((r_aw_cap || (i_axi_awvalid && !r_aw_cap)) &&
            (r_w_cap  || (i_axi_wvalid  && !r_w_cap)))
          w_wstate_nxt = W_ISSUE;
      end
      W_ISSUE: begin
        w_wr_en      = w_wr_in_range;
        w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        o_axi_bvalid = 1'b1;
        if (i_axi_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_aw_hs = i_axi_awvalid && o_axi_awready;
  assign w_w_hs  = i_axi_wvalid  && o_axi_wready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wstate <= W_IDLE;
      r_aw_cap <= 1'b0;
      r_w_cap  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= OKAY;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_aw_cap <= 1'b1;
        r_awaddr <= i_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_cap <= 1'b1;
        r_wdata <= i_axi_wdata;
        r_wstrb <= i_axi_wstrb;
      end
      if (r_wstate == W_ISSUE)
        r_bresp <= w_wr_in_range ? OKAY : SLVERR;
      if (r_wstate == W_RESP && i_axi_bready) begin
        r_aw_cap <= 1'b0;
        r_w_cap  <= 1'b0;
      end
    end
  end

  // ---------------- read FSM ----------------
  always_comb begin
    w_rstate_nxt  = r_rstate;
    o_axi_arready = 1'b0;
    o_axi_rvalid  = 1'b0;
    w_rd_en       = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        o_axi_arready = 1'b1;
        if (i_axi_arvalid) w_rstate_nxt = R_ISSUE;
      end
      R_ISSUE: begin
        if (!w_rd_in_range) begin
          w_rstate_nxt = R_RESP;
        end else if (!w_wr_en) begin
          // Yield to a concurrent write so the read observes the new value.
          w_rd_en      = 1'b1;
          w_rstate_nxt = R_WAIT;
        end
      end
      R_WAIT: w_rstate_nxt = R_RESP;
      R_RESP: begin
        o_axi_rvalid = 1'b1;
        if (i_axi_rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_ar_hs = i_axi_arvalid && o_axi_arready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rstate <= R_IDLE;
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) r_araddr <= i_axi_araddr;
      if (r_rstate == R_ISSUE && !w_rd_in_range) begin
        r_rdata <= '0;
        r_rresp <= SLVERR;
      end
      if (r_rstate == R_WAIT) begin
        r_rdata <= i_reg_rd_data;
        r_rresp <= OKAY;
      end
    end
  end

  assign o_axi_bresp   = r_bresp;
  assign o_axi_rdata   = r_rdata;
  assign o_axi_rresp   = r_rresp;
  assign o_reg_wr_en   = w_wr_en;
  assign o_reg_wr_idx  = r_awaddr[RW+OFF-1:OFF];
  assign o_reg_wr_data = r_wdata;
  assign o_reg_wr_strb = r_wstrb;
  assign o_reg_rd_en   = w_rd_en;
  assign o_reg_rd_idx  = r_araddr[RW+OFF-1:OFF];

endmodule

// File: tb/tb_idft_axi4lite_slave.sv
// tb/tb_idft_axi4lite_slave.sv - self-checking bench for idft_axi4lite_slave
module tb_idft_axi4lite_slave;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;
  logic        wr_en, rd_en;
  logic [8:0]  wr_idx, rd_idx;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic [63:0] reg_rd_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idft_axi4lite_slave dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .o_axi_awready(awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid), .o_axi_wready(wready),
    .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .i_axi_bready(bready),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .o_axi_arready(arready),
    .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .o_reg_wr_en(wr_en), .o_reg_wr_idx(wr_idx), .o_reg_wr_data(wr_data), .o_reg_wr_strb(wr_strb),
    .o_reg_rd_en(rd_en), .o_reg_rd_idx(rd_idx), .i_reg_rd_data(reg_rd_data)
  );

  // Register-file model: byte-strobed writes, read data valid the cycle after rd_en,
  // junk otherwise so a mistimed capture is visible.
  logic [63:0] mem [512];
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [8:0]  last_wr_idx, last_rd_idx;
  logic [63:0] last_wr_data;
  logic [7:0]  last_wr_strb;

  initial for (int i = 0; i < 512; i++) mem[i] = '0;

  always @(posedge clk) begin
    reg_rd_data <= 64'hDEAD_BEEF_0BAD_F00D;
    if (wr_en && rd_en) both_cnt <= both_cnt + 1;
    if (wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_idx  <= wr_idx;
      last_wr_data <= wr_data;
      last_wr_strb <= wr_strb;
      for (int b = 0; b < 8; b++)
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
    if (rd_en) begin
      rd_cnt      <= rd_cnt + 1;
      last_rd_idx <= rd_idx;
      reg_rd_data <= mem[rd_idx];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          output logic [1:0] resp);
    bit ok = 0;
    bit aw_hs, w_hs;
    resp = 2'bxx;
    @(negedge clk);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
    for (int n = 0; n < 50 && !ok; n++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if (bvalid) begin resp = bresp; ok = 1; end
      @(negedge clk);
      if (aw_hs) awvalid = 0;
      if (w_hs) wvalid = 0;
    end
    awvalid = 0; wvalid = 0; bready = 0;
    if (!ok) check("write_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp);
    bit ok = 0;
    bit ar_hs;
    d = 'x; resp = 2'bxx;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    for (int n = 0; n < 50 && !ok; n++) begin
      ar_hs = arvalid && arready;
      if (rvalid) begin d = rdata; resp = rresp; ok = 1; end
      @(negedge clk);
      if (ar_hs) arvalid = 0;
    end
    arvalid = 0; rready = 0;
    if (!ok) check("read_timeout", 0, 1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
    int          exp_pulses;
    logic [8:0]  exp_idx;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, awready, 1);
    check({tag, "_wready"},  wready, 1);
    check({tag, "_arready"}, arready, 1);
    check({tag, "_bvalid"},  bvalid, 0);
    check({tag, "_rvalid"},  rvalid, 0);
    check({tag, "_bresp"},   bresp, 0);
    check({tag, "_rresp"},   rresp, 0);
    check({tag, "_rdata"},   rdata, 0);
    check({tag, "_wr_en"},   wr_en, 0);
    check({tag, "_rd_en"},   rd_en, 0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [63:0] d;
    int wc0, rc0;

    vecs[0]  = '{1, 32'h008, 64'h0003_0002_0001_0000, 8'hFF, 2'b00, 1, 9'h001, 64'h0};
    vecs[1]  = '{0, 32'h008, 64'h0, 8'h00, 2'b00, 1, 9'h001, 64'h0003_0002_0001_0000};
    vecs[2]  = '{1, 32'h108, 64'h1, 8'hFF, 2'b00, 1, 9'h021, 64'h0};
    vecs[3]  = '{0, 32'h108, 64'h0, 8'h00, 2'b00, 1, 9'h021, 64'h1};
    vecs[4]  = '{1, 32'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2'b00, 1, 9'h002, 64'h0};
    vecs[5]  = '{0, 32'h010, 64'h0, 8'h00, 2'b00, 1, 9'h002, 64'h0000_0000_FFFF_FFFF};
    vecs[6]  = '{1, 32'h010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 2'b00, 1, 9'h002, 64'h0};
    vecs[7]  = '{0, 32'h010, 64'h0, 8'h00, 2'b00, 1, 9'h002, 64'h0000_0000_FFFF_FFFF};
    vecs[8]  = '{1, 32'h1000, 64'h5, 8'hFF, 2'b10, 0, 9'h000, 64'h0};
    vecs[9]  = '{0, 32'h1000, 64'h0, 8'h00, 2'b10, 0, 9'h000, 64'h0};
    vecs[10] = '{0, 32'h00F, 64'h0, 8'h00, 2'b00, 1, 9'h001, 64'h0003_0002_0001_0000};
    vecs[11] = '{1, 32'hFFF, 64'h55, 8'hFF, 2'b00, 1, 9'h1FF, 64'h0};
    vecs[12] = '{0, 32'hFF8, 64'h0, 8'h00, 2'b00, 1, 9'h1FF, 64'h55};
    vecs[13] = '{0, 32'h8000_0000, 64'h0, 8'h00, 2'b10, 0, 9'h000, 64'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_ni = 1;
    @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < 14; i++) begin
      wc0 = wr_cnt; rc0 = rd_cnt;
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("v%0d_wr_pulses", i), wr_cnt - wc0, vecs[i].exp_pulses);
        if (vecs[i].exp_pulses != 0) begin
          check($sformatf("v%0d_wr_idx", i), last_wr_idx, vecs[i].exp_idx);
          check($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].data);
          check($sformatf("v%0d_wr_strb", i), last_wr_strb, vecs[i].strb);
        end
      end else begin
        do_read(vecs[i].addr, d, resp);
        check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
        check($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
        check($sformatf("v%0d_rd_pulses", i), rd_cnt - rc0, vecs[i].exp_pulses);
        if (vecs[i].exp_pulses != 0)
          check($sformatf("v%0d_rd_idx", i), last_rd_idx, vecs[i].exp_idx);
      end
    end

    // Same-cycle AW/W: wr_en the cycle after the handshake, bvalid the cycle after that
    @(negedge clk);
    awaddr = 32'h008; wdata = 64'h0003_0002_0001_0000; wstrb = 8'hFF;
    awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    check("lat_wr_en", wr_en, 1);
    check("lat_wr_idx", wr_idx, 9'h001);
    check("lat_wr_data", wr_data, 64'h0003_0002_0001_0000);
    check("lat_awready_busy", awready, 0);
    check("lat_bvalid_early", bvalid, 0);
    @(negedge clk);
    check("lat_wr_en_once", wr_en, 0);
    check("lat_bvalid", bvalid, 1);
    check("lat_bresp", bresp, 2'b00);
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("lat_bvalid_done", bvalid, 0);
    check("lat_awready_back", awready, 1);

    // W ahead of AW by five cycles
    wc0 = wr_cnt;
    awaddr = 32'h100; wdata = 64'h1; wstrb = 8'hFF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    for (int c = 1; c < 5; c++) begin
      check($sformatf("wfirst_wready_c%0d", c), wready, 0);
      check($sformatf("wfirst_awready_c%0d", c), awready, 1);
      check($sformatf("wfirst_no_wr_c%0d", c), wr_en, 0);
      @(negedge clk);
    end
    awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    check("wfirst_wr_en", wr_en, 1);
    check("wfirst_wr_idx", wr_idx, 9'h020);
    @(negedge clk);
    check("wfirst_bvalid", bvalid, 1);
    check("wfirst_bresp", bresp, 2'b00);
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("wfirst_pulses", wr_cnt - wc0, 1);

    // Read 0x108 with rready held low for 10 cycles
    rc0 = rd_cnt;
    araddr = 32'h108; arvalid = 1; rready = 0;
    @(negedge clk);
    arvalid = 0;
    check("rbp_rd_en", rd_en, 1);
    check("rbp_rd_idx", rd_idx, 9'h021);
    @(negedge clk);
    check("rbp_rd_en_once", rd_en, 0);
    check("rbp_rvalid_early", rvalid, 0);
    @(negedge clk);
    check("rbp_rvalid", rvalid, 1);
    check("rbp_rdata", rdata, 64'h1);
    check("rbp_rresp", rresp, 2'b00);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("rbp_hold_rvalid_%0d", c), rvalid, 1);
      check($sformatf("rbp_hold_rdata_%0d", c), rdata, 64'h1);
      check($sformatf("rbp_hold_arready_%0d", c), arready, 0);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    check("rbp_rvalid_done", rvalid, 0);
    check("rbp_arready_back", arready, 1);
    check("rbp_pulses", rd_cnt - rc0, 1);

    // Write and read of idx 3 eligible to issue in the same cycle
    awaddr = 32'h018; wdata = 64'h1234_5678_9ABC_DEF0; wstrb = 8'hFF;
    araddr = 32'h018; awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("conf_wr_first", wr_en, 1);
    check("conf_rd_stall", rd_en, 0);
    @(negedge clk);
    check("conf_rd_next", rd_en, 1);
    check("conf_rd_idx", rd_idx, 9'h003);
    check("conf_wr_gone", wr_en, 0);
    bready = 1;
    @(negedge clk);
    bready = 0;
    rready = 1;
    begin
      bit got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        if (rvalid) begin
          got = 1;
          check("conf_rdata", rdata, 64'h1234_5678_9ABC_DEF0);
          check("conf_rresp", rresp, 2'b00);
        end
        @(negedge clk);
      end
      if (!got) check("conf_rvalid_timeout", 0, 1);
    end
    rready = 0;
    check("conf_no_overlap", both_cnt, 0);

    // Reset while bvalid is held
    awaddr = 32'h020; wdata = 64'h77; wstrb = 8'hFF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("rstb_bvalid_before", bvalid, 1);
    rst_ni = 0;
    #1;
    check_reset_outputs("rstb");
    @(negedge clk);
    rst_ni = 1;
    @(negedge clk);
    check("rstb_bvalid_after", bvalid, 0);

    // Reset while the read FSM waits for register data
    rc0 = rd_cnt;
    araddr = 32'h020; arvalid = 1; rready = 1;
    @(negedge clk);
    arvalid = 0;
    check("rstr_rd_en", rd_en, 1);
    @(negedge clk);
    rst_ni = 0;
    #1;
    check_reset_outputs("rstr");
    repeat (2) @(negedge clk);
    rst_ni = 1;
    repeat (3) begin
      @(negedge clk);
      check("rstr_no_rvalid", rvalid, 0);
    end
    rready = 0;
    check("rstr_pulses", rd_cnt - rc0, 1);

    // Normal traffic after reset
    do_read(32'h020, d, resp);
    check("post_rdata", d, 64'h77);
    check("post_rresp", resp, 2'b00);
    do_write(32'h028, 64'hCAFE, 8'h03, resp);
    check("post_bresp", resp, 2'b00);
    do_read(32'h028, d, resp);
    check("post_rdata2", d, 64'hCAFE);
    check("final_no_overlap", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
